// File: rtl/regfile_pkg.sv
// Shared sizes and types for the LEGv8 register file and its read-port operand selectors.
package regfile_pkg;

    localparam int WIDTH = 64;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [AW-1:0]    raddr_t;

    // XZR: index hard-wired to zero, never written and always read as 0.
    localparam raddr_t ZREG = raddr_t'(31);

endpackage

// File: rtl/regfile_operand_sel.sv
// Combinational operand selection for one read port: 32:1 storage mux, with XZR taking
// priority over the same-cycle write bypass, which in turn takes priority over storage.
module regfile_operand_sel
    import regfile_pkg::*;
(
    input  logic [NREGS*WIDTH-1:0] regsFlat,
    input  logic [AW-1:0]          readAddr,
    input  logic                   writeEn,
    input  logic [AW-1:0]          writeAddr,
    input  logic [WIDTH-1:0]       writeData,
    output logic [WIDTH-1:0]       operand
);

    always_comb begin
        operand = regsFlat[int'(readAddr)*WIDTH +: WIDTH];
        if (readAddr == ZREG) begin
            operand = '0;
        end else if (writeEn && (writeAddr == readAddr)) begin
            operand = writeData;
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// 32 x 64-bit register file: one write port and two registered read ports with a
// one-cycle read latency and same-edge write-to-read bypass.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [AW-1:0]    WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             rd_req,
    input  logic [AW-1:0]    ReadRegister1,
    input  logic [AW-1:0]    ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             rd_valid
);

    logic [NREGS*WIDTH-1:0] regsFlat;
    word_t                  operandA;
    word_t                  operandB;

    regfile_operand_sel selA (
        .regsFlat  (regsFlat),
        .readAddr  (ReadRegister1),
        .writeEn   (RegWrite),
        .writeAddr (WriteRegister),
        .writeData (WriteData),
        .operand   (operandA)
    );

    regfile_operand_sel selB (
        .regsFlat  (regsFlat),
        .readAddr  (ReadRegister2),
        .writeEn   (RegWrite),
        .writeAddr (WriteRegister),
        .writeData (WriteData),
        .operand   (operandB)
    );

    // Operands are captured only on an accepted request so they hold between requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            regsFlat  <= '0;
            ReadData1 <= '0;
            ReadData2 <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (RegWrite && (WriteRegister != ZREG)) begin
                regsFlat[int'(WriteRegister)*WIDTH +: WIDTH] <= WriteData;
            end
            rd_valid <= rd_req;
            if (rd_req) begin
                ReadData1 <= operandA;
                ReadData2 <= operandB;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// Self-checking bench for regfile_read_port: directed vector table, a reset-vs-write
// sequence, then randomized traffic against an array-based reference model.
module tb_regfile_read_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic        rd_req;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic        rd_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        req;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] e1;
        logic [63:0] e2;
        logic        ev;
    } vec_t;

    vec_t vecs[$];

    regfile_read_port dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .rd_req        (rd_req),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .rd_valid      (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic addVec(input string n, input logic rst, input logic we, input logic [4:0] wa,
                          input logic [63:0] wd, input logic req, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [63:0] e1, input logic [63:0] e2,
                          input logic ev);
        vec_t v;
        v.name = n; v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.req = req;
        v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2; v.ev = ev;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, let the edge capture them, then sample 1 time unit later.
    task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                                 input logic [63:0] wd, input logic req,
                                 input logic [4:0] r1, input logic [4:0] r2);
        reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
        rd_req = req; ReadRegister1 = r1; ReadRegister2 = r2;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string n, input logic [63:0] e1, input logic [63:0] e2,
                               input logic ev);
        checks += 3;
        if (ReadData1 !== e1) begin
            errors++;
            $display("[TB] FAIL %s.ReadData1: got %h expected %h", n, ReadData1, e1);
        end
        if (ReadData2 !== e2) begin
            errors++;
            $display("[TB] FAIL %s.ReadData2: got %h expected %h", n, ReadData2, e2);
        end
        if (rd_valid !== ev) begin
            errors++;
            $display("[TB] FAIL %s.rd_valid: got %b expected %b", n, rd_valid, ev);
        end
    endtask

    // Architectural operand rule: XZR reads 0, a same-cycle write wins, else stored value.
    function automatic logic [63:0] operandOf(input logic [63:0] regs [32], input logic [4:0] r,
                                              input logic we, input logic [4:0] wa,
                                              input logic [63:0] wd);
        if (r == 5'd31) return 64'd0;
        if (we && wa == r) return wd;
        return regs[r];
    endfunction

    localparam logic [63:0] DEAD = 64'hDEADBEEF_CAFEF00D;

    initial begin
        logic [63:0] model [32];
        logic [63:0] e1, e2;
        logic        ev, rst, we, req;
        logic [4:0]  wa, r1, r2;
        logic [63:0] wd;

        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        rd_req = 1'b0; ReadRegister1 = '0; ReadRegister2 = '0;

        //      name         rst we wa     wd             req r1     r2     e1       e2       ev
        addVec("reset",      1, 0, 5'd0,  64'd0,          1, 5'd5,  5'd31, 64'd0,   64'd0,   0);
        addVec("rstRead",    0, 0, 5'd0,  64'd0,          1, 5'd5,  5'd31, 64'd0,   64'd0,   1);
        addVec("write3",     0, 1, 5'd3,  DEAD,           0, 5'd0,  5'd0,  64'd0,   64'd0,   0);
        addVec("read3",      0, 0, 5'd0,  64'd0,          1, 5'd3,  5'd3,  DEAD,    DEAD,    1);
        addVec("bypass",     0, 1, 5'd7,  64'h1234,       1, 5'd7,  5'd8,  64'h1234, 64'd0,  1);
        addVec("read7",      0, 0, 5'd0,  64'd0,          1, 5'd7,  5'd3,  64'h1234, DEAD,   1);
        addVec("xzrBypass",  0, 1, 5'd31, '1,             1, 5'd31, 5'd31, 64'd0,   64'd0,   1);
        addVec("xzrRead",    0, 0, 5'd0,  64'd0,          1, 5'd31, 5'd7,  64'd0,   64'h1234, 1);
        addVec("holdReq",    0, 0, 5'd0,  64'd0,          1, 5'd3,  5'd7,  DEAD,    64'h1234, 1);
        addVec("hold1",      0, 1, 5'd3,  64'h55,         0, 5'd0,  5'd0,  DEAD,    64'h1234, 0);
        addVec("hold2",      0, 0, 5'd0,  64'd0,          0, 5'd1,  5'd2,  DEAD,    64'h1234, 0);
        addVec("hold3",      0, 0, 5'd0,  64'd0,          0, 5'd3,  5'd3,  DEAD,    64'h1234, 0);
        addVec("readNew",    0, 0, 5'd0,  64'd0,          1, 5'd3,  5'd3,  64'h55,  64'h55,  1);
        addVec("midReset",   1, 0, 5'd0,  64'd0,          1, 5'd3,  5'd7,  64'd0,   64'd0,   0);
        addVec("postReset",  0, 0, 5'd0,  64'd0,          1, 5'd3,  5'd7,  64'd0,   64'd0,   1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                          vecs[i].req, vecs[i].r1, vecs[i].r2);
            checkOutput(vecs[i].name, vecs[i].e1, vecs[i].e2, vecs[i].ev);
        end

        // Reset must beat a concurrent write and request; the write must not land.
        applyStimulus(1, 1, 5'd4, 64'h99, 1, 5'd4, 5'd4);
        checkOutput("rstVsWrite", 64'd0, 64'd0, 1'b0);
        applyStimulus(0, 0, 5'd0, 64'd0, 1, 5'd4, 5'd4);
        checkOutput("rstVsWriteRead", 64'd0, 64'd0, 1'b1);

        // Write-then-read in consecutive cycles, then back-to-back requests.
        applyStimulus(0, 1, 5'd12, 64'hA5A5, 0, 5'd0, 5'd0);
        checkOutput("w12", 64'd0, 64'd0, 1'b0);
        applyStimulus(0, 1, 5'd13, 64'h77, 1, 5'd12, 5'd13);
        checkOutput("r12byp13", 64'hA5A5, 64'h77, 1'b1);
        applyStimulus(0, 0, 5'd0, 64'd0, 1, 5'd13, 5'd12);
        checkOutput("r13r12", 64'h77, 64'hA5A5, 1'b1);

        e1 = '0; e2 = '0; ev = 1'b0;
        foreach (model[k]) model[k] = '0;
        for (int i = 0; i < 400; i++) begin
            rst = (i == 0) || ($urandom_range(0, 49) == 0);
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 31));
            wd  = {$urandom, $urandom};
            req = ($urandom_range(0, 3) != 0);
            r1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            if (rst) begin
                foreach (model[k]) model[k] = '0;
                e1 = '0; e2 = '0; ev = 1'b0;
            end else begin
                if (req) begin
                    e1 = operandOf(model, r1, we, wa, wd);
                    e2 = operandOf(model, r2, we, wa, wd);
                end
                ev = req;
                if (we && wa != 5'd31) model[wa] = wd;
            end
            applyStimulus(rst, we, wa, wd, req, r1, r2);
            checkOutput($sformatf("rand%0d", i), e1, e2, ev);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
